// File: rtl/d8m_emu_pkg.sv
// Shared types and constants for the D8M sensor emulator.
package d8m_emu_pkg;

    localparam int unsigned PIX_W    = 12;
    localparam int unsigned FCNT_W   = 16;
    localparam int unsigned NUM_BARS = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VBLANK     = 3'd1,
        ST_FV_PRE     = 3'd2,
        ST_LINE_ACT   = 3'd3,
        ST_LINE_BLANK = 3'd4,
        ST_FV_POST    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CONST = 2'd2,
        PAT_RSVD  = 2'd3
    } pat_t;

    // Colour channel masks in {R,G,B} order.
    localparam logic [2:0] RGB_R = 3'b100;
    localparam logic [2:0] RGB_G = 3'b010;
    localparam logic [2:0] RGB_B = 3'b001;

    // Bayer phase {y[0], x[0]}.
    localparam logic [1:0] BAYER_G_R = 2'b00;
    localparam logic [1:0] BAYER_R   = 2'b01;
    localparam logic [1:0] BAYER_B   = 2'b10;
    localparam logic [1:0] BAYER_G_B = 2'b11;

    // Bar colour table: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    endfunction

    // Colour channel sampled at a given Bayer phase.
    function automatic logic [2:0] bayer_rgb(input logic [1:0] phase);
        case (phase)
            BAYER_R: bayer_rgb = RGB_R;
            BAYER_B: bayer_rgb = RGB_B;
            default: bayer_rgb = RGB_G;
        endcase
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        umax = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/d8m_sensor_emulator_if.sv
// Raw parallel sensor bus: frame valid, line valid, Bayer pixel.
interface d8m_sensor_emulator_if;
    import d8m_emu_pkg::*;

    logic             fval;
    logic             lval;
    logic [PIX_W-1:0] d;

    modport master (output fval, output lval, output d);
    modport slave  (input  fval, input  lval, input  d);
endinterface

// File: rtl/d8m_emu_pattern.sv
// Test-pattern generator; one register stage, output forced to 0 outside active pixels.
module d8m_emu_pattern
    import d8m_emu_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [PIX_W-1:0] frame_lsb,
    input  pat_t             mode,
    input  logic [PIX_W-1:0] const_val,
    output logic [PIX_W-1:0] d
);

    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

    logic [2:0]       bar_idx_c;
    logic             bar_hit_c;
    logic [PIX_W-1:0] pix_c;

    // Pixel value for the current coordinate and mode.
    always_comb begin
        bar_idx_c = 3'(32'(x) / BAR_W);
        bar_hit_c = |(bar_rgb(bar_idx_c) & bayer_rgb({y[0], x[0]}));
        pix_c     = bar_hit_c ? {PIX_W{1'b1}} : '0;
        case (mode)
            PAT_RAMP:  pix_c = PIX_W'(x) + PIX_W'(y) + frame_lsb;
            PAT_CONST: pix_c = const_val;
            default:   pix_c = bar_hit_c ? {PIX_W{1'b1}} : '0;
        endcase
    end

    // Output register, blanked whenever the line is inactive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d <= '0;
        end else if (valid) begin
            d <= pix_c;
        end else begin
            d <= '0;
        end
    end

endmodule

// File: rtl/d8m_sensor_emulator.sv
// Synthetic D8M raw sensor source: programmable frame timing plus Bayer test patterns.
module d8m_sensor_emulator
    import d8m_emu_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_BLANK  = 45000,
    parameter int unsigned FV_TO_LV = 4,
    parameter int unsigned LV_TO_FV = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [1:0]              pattern_sel,
    input  logic [PIX_W-1:0]        const_val,
    d8m_sensor_emulator_if.master   bus,
    output logic [FCNT_W-1:0]       frame_cnt,
    output logic                    busy
);

    localparam int unsigned MAX_LEN = umax(umax(umax(H_ACTIVE, V_BLANK), umax(H_BLANK, FV_TO_LV)), LV_TO_FV);
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned X_W     = $clog2(H_ACTIVE);
    localparam int unsigned Y_W     = $clog2(V_ACTIVE);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    pat_t               mode_q;
    logic [PIX_W-1:0]   const_q;
    logic               latch_c;
    logic               in_frame_c;
    logic               line_c;
    logic               fval_q;
    logic               lval_q;
    logic [PIX_W-1:0]   d_q;

    // State, counters, per-frame pattern latch and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            mode_q    <= PAT_BARS;
            const_q   <= '0;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (latch_c) begin
                mode_q  <= pat_t'(pattern_sel);
                const_q <= const_val;
            end
            fval_q <= in_frame_c;
            lval_q <= line_c;
            busy   <= (state_q != ST_IDLE);
            if (fval_q && !in_frame_c) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    // Next-state, counter reloads and frame/line qualifiers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = '0;
        y_d        = y_q;
        latch_c    = 1'b0;
        in_frame_c = 1'b0;
        line_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_VBLANK;
                    cnt_d   = CNT_W'(V_BLANK - 1);
                end
            end
            ST_VBLANK: begin
                if (cnt_q == '0) begin
                    state_d = ST_FV_PRE;
                    cnt_d   = CNT_W'(FV_TO_LV - 1);
                    latch_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FV_PRE: begin
                in_frame_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_LINE_ACT;
                    cnt_d   = CNT_W'(H_ACTIVE - 1);
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LINE_ACT: begin
                in_frame_c = 1'b1;
                line_c     = 1'b1;
                if (cnt_q == '0) begin
                    if (y_q < Y_W'(V_ACTIVE - 1)) begin
                        state_d = ST_LINE_BLANK;
                        cnt_d   = CNT_W'(H_BLANK - 1);
                    end else begin
                        state_d = ST_FV_POST;
                        cnt_d   = CNT_W'(LV_TO_FV - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    x_d   = x_q + X_W'(1);
                end
            end
            ST_LINE_BLANK: begin
                in_frame_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_LINE_ACT;
                    cnt_d   = CNT_W'(H_ACTIVE - 1);
                    y_d     = y_q + Y_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FV_POST: begin
                in_frame_c = 1'b1;
                if (cnt_q == '0) begin
                    if (enable) begin
                        state_d = ST_VBLANK;
                        cnt_d   = CNT_W'(V_BLANK - 1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    d8m_emu_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_pattern (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (line_c),
        .x         (x_q),
        .y         (y_q),
        .frame_lsb (frame_cnt[PIX_W-1:0]),
        .mode      (mode_q),
        .const_val (const_q),
        .d         (d_q)
    );

    assign bus.fval = fval_q;
    assign bus.lval = lval_q;
    assign bus.d    = d_q;

endmodule

// File: tb/tb_d8m_sensor_emulator.sv
// Directed bench for the D8M sensor emulator using a small 8x4 frame.
module tb_d8m_sensor_emulator;
    import d8m_emu_pkg::*;

    localparam int unsigned H_ACTIVE = 8;
    localparam int unsigned V_ACTIVE = 4;
    localparam int unsigned H_BLANK  = 4;
    localparam int unsigned V_BLANK  = 10;
    localparam int unsigned FV_TO_LV = 2;
    localparam int unsigned LV_TO_FV = 3;

    // Sample index i is taken at the negedge after the i-th edge following enable.
    localparam int FR0     = 11;
    localparam int FV_HIGH = 49;
    localparam int PERIOD  = 59;
    localparam int FALL0   = FR0 + FV_HIGH;
    localparam int PITCH   = 12;
    localparam int L0      = FR0 + 2;
    localparam int CAP     = 140;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] const_val;
    logic [15:0] frame_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic        cap_fv   [CAP];
    logic        cap_lv   [CAP];
    logic        cap_busy [CAP];
    logic [11:0] cap_d    [CAP];
    logic [15:0] cap_fc   [CAP];

    logic [11:0] bars0 [8];
    logic [11:0] bars1 [8];

    d8m_sensor_emulator_if bus ();

    d8m_sensor_emulator #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_BLANK  (V_BLANK),
        .FV_TO_LV (FV_TO_LV),
        .LV_TO_FV (LV_TO_FV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .const_val   (const_val),
        .bus         (bus),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] sel, input logic [11:0] cv);
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pattern_sel = sel;
        const_val   = cv;
        reset_n     = 1'b1;
        enable      = 1'b1;
    endtask

    task automatic capture(input int n, input int chg_at, input logic [11:0] chg_val, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_fv[i]   = bus.fval;
            cap_lv[i]   = bus.lval;
            cap_d[i]    = bus.d;
            cap_fc[i]   = frame_cnt;
            cap_busy[i] = busy;
            if (i == chg_at)  const_val = chg_val;
            if (i == drop_at) enable = 1'b0;
        end
    endtask

    function automatic logic sig(input bit lv, input int i);
        return lv ? cap_lv[i] : cap_fv[i];
    endfunction

    function automatic int rise_at(input bit lv, input int from);
        for (int i = (from < 1 ? 1 : from); i < CAP; i++) begin
            if (sig(lv, i) === 1'b1 && sig(lv, i - 1) === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int run_len(input bit lv, input int at);
        int n = 0;
        if (at < 0) return -1;
        for (int i = at; i < CAP; i++) begin
            if (sig(lv, i) !== 1'b1) break;
            n++;
        end
        return n;
    endfunction

    function automatic int window_violations(input int n);
        int v = 0;
        for (int i = 0; i < n; i++) begin
            if (cap_lv[i] === 1'b1 && cap_fv[i] !== 1'b1) v++;
            if (cap_lv[i] !== 1'b1 && cap_d[i] !== 12'h000) v++;
        end
        return v;
    endfunction

    initial begin
        int r, n_lv, bad_len, bad_gap, prev, last_end, cnt;

        bars0 = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000};
        bars1 = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'h000};

        reset_n     = 1'b0;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        const_val   = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_fval", 32'(bus.fval), 0);
        check("rst_lval", 32'(bus.lval), 0);
        check("rst_d", 32'(bus.d), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);

        // Frame timing and colour bars.
        start(2'd0, 12'h000);
        capture(CAP, -1, 12'h000, -1);
        r = rise_at(1'b0, 1);
        check("fval_first_rise", 32'(r), 32'(FR0));
        check("fval_high_len", 32'(run_len(1'b0, r)), 32'(FV_HIGH));
        check("frame_period", 32'(rise_at(1'b0, r + 1) - r), 32'(PERIOD));
        check("busy_in_vblank", 32'(cap_busy[5]), 1);
        check("frame_cnt_before_fall", 32'(cap_fc[FALL0 - 1]), 0);
        check("frame_cnt_at_fall", 32'(cap_fc[FALL0]), 1);
        check("fval_low_at_fall", 32'(cap_fv[FALL0]), 0);
        n_lv = 0; bad_len = 0; bad_gap = 0; prev = -1; last_end = 0;
        for (int p = rise_at(1'b1, FR0); p >= 0 && p < FALL0; p = rise_at(1'b1, p + 1)) begin
            n_lv++;
            if (run_len(1'b1, p) != 8) bad_len++;
            if (prev >= 0 && p - (prev + 8) != 4) bad_gap++;
            prev     = p;
            last_end = p + run_len(1'b1, p);
        end
        check("lval_pulses", 32'(n_lv), 4);
        check("lval_len_bad", 32'(bad_len), 0);
        check("lval_gap_bad", 32'(bad_gap), 0);
        check("fv_to_lv", 32'(rise_at(1'b1, FR0) - FR0), 2);
        check("lv_to_fv", 32'(FALL0 - last_end), 3);
        check("window_bars", 32'(window_violations(CAP)), 0);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("bars_l0_x%0d", j), 32'(cap_d[L0 + j]), 32'(bars0[j]));
            check($sformatf("bars_l1_x%0d", j), 32'(cap_d[L0 + PITCH + j]), 32'(bars1[j]));
        end

        // Ramp in frame 0 and frame 1, line 2.
        start(2'd1, 12'h000);
        capture(CAP, -1, 12'h000, -1);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("ramp_f0_x%0d", j), 32'(cap_d[L0 + 2 * PITCH + j]), 32'(2 + j));
            check($sformatf("ramp_f1_x%0d", j), 32'(cap_d[L0 + 2 * PITCH + PERIOD + j]), 32'(3 + j));
        end

        // Constant pattern with a mid-frame const_val change.
        start(2'd2, 12'hA5C);
        capture(CAP, 30, 12'h123, -1);
        cnt = 0;
        for (int i = FR0; i < FALL0; i++) if (cap_lv[i] === 1'b1 && cap_d[i] === 12'hA5C) cnt++;
        check("const_f0_pixels", 32'(cnt), 32);
        check("const_f0_after_change", 32'(cap_d[L0 + 2 * PITCH]), 32'h0A5C);
        cnt = 0;
        for (int i = FR0 + PERIOD; i < FALL0 + PERIOD; i++) if (cap_lv[i] === 1'b1 && cap_d[i] === 12'h123) cnt++;
        check("const_f1_pixels", 32'(cnt), 32);
        check("window_const", 32'(window_violations(CAP)), 0);

        // Drop enable during line 1; frame must complete and stop.
        start(2'd0, 12'h000);
        capture(CAP, -1, 12'h000, 28);
        n_lv = 0;
        for (int p = rise_at(1'b1, FR0); p >= 0 && p < FALL0; p = rise_at(1'b1, p + 1)) n_lv++;
        check("drop_lval_pulses", 32'(n_lv), 4);
        check("drop_fval_len", 32'(run_len(1'b0, FR0)), 32'(FV_HIGH));
        check("drop_busy_last_fval", 32'(cap_busy[FALL0 - 1]), 1);
        check("drop_busy_at_fall", 32'(cap_busy[FALL0]), 0);
        check("drop_busy_after_fall", 32'(cap_busy[FALL0 + 1]), 0);
        cnt = 0;
        for (int i = FALL0; i < CAP; i++) if (cap_fv[i] !== 1'b0) cnt++;
        check("drop_no_more_fval", 32'(cnt), 0);
        check("drop_frame_cnt", 32'(cap_fc[CAP - 1]), 1);

        // Reset during LINE_ACT of frame 1, then restart.
        start(2'd2, 12'h007);
        capture(75, -1, 12'h000, -1);
        check("pre_rst_lval", 32'(cap_lv[74]), 1);
        check("pre_rst_frame_cnt", 32'(cap_fc[74]), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_fval", 32'(bus.fval), 0);
        check("mid_rst_lval", 32'(bus.lval), 0);
        check("mid_rst_d", 32'(bus.d), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check("mid_rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        capture(20, -1, 12'h000, -1);
        check("restart_fval_low0", 32'(cap_fv[0]), 0);
        check("restart_fval_rise", 32'(rise_at(1'b0, 1)), 32'(FR0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
